i2c_addr_match: RTL and testbench
=================================

I2C_ADDR_MATCH -- requirements
Module: i2c_addr_match

Interface
REQ-001 Parameter NUM_ADDR, default 2, number of programmable slave-address slots (range 1..4).
REQ-002 Parameter TEN_BIT_EN, default 1, enables the 10-bit addressing path; when 0, 10-bit headers never match.
REQ-003 Parameter GC_EN, default 1, enables general-call (address 0x00, write) recognition.
REQ-004 FPGA_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 SCL, SCL_prev  input  1 each  synchronised bus clock and its previous-cycle copy; a sample edge is SCL=1 and SCL_prev=0.
REQ-007 SDA  input  1  synchronised bus data.
REQ-008 enable  input  1  high from the cycle after START detection until STOP or repeated START.
REQ-009 restart  input  1  one-cycle pulse on repeated START; it aborts the current decode and does not clear the 10-bit history.
REQ-010 addr_table  input  NUM_ADDR*10  slot i occupies bits [10i+9:10i].
REQ-011 addr_is_10bit  input  NUM_ADDR  slot i is 10-bit when set; otherwise only bits [6:0] of the slot are compared.
REQ-012 done  output  1  one-cycle pulse when the address phase is resolved, whether matched or not.
REQ-013 selected, general_call, rw  output  1 each  decode result; valid from done until enable falls or restart.
REQ-014 match_idx  output  $clog2(NUM_ADDR) (min 1)  index of the matching slot.

Function
REQ-015 States: IDLE, BYTE1, ACK1, BYTE2, RESOLVED; the state enum is held in the shared package.
REQ-016 IDLE -> BYTE1 when enable=1; any state -> IDLE when enable=0 or restart=1; all outputs clear on that transition.
REQ-017 BYTE1 shifts SDA in MSB-first on each sample edge; the 8th edge supplies the rw bit.
REQ-018 7-bit decode: if byte1[7:3]!=5'b11110, compare byte1[7:1] against each 7-bit slot; the lowest matching index wins.
REQ-019 General call: byte1==8'h00 with GC_EN=1 sets selected=1, general_call=1, match_idx=0; byte1==8'h01 (START byte) never matches.
REQ-020 10-bit header: byte1[7:3]==5'b11110 and TEN_BIT_EN=1 with rw=0 -> ACK1 if any 10-bit slot has [9:8]==byte1[2:1]; otherwise resolve unmatched.
REQ-021 ACK1 ignores exactly one sample edge (the ACK clock), then enters BYTE2; BYTE2 collects 8 bits compared against slot[7:0].
REQ-022 10-bit read: header with rw=1, after a restart that followed a 10-bit write match with the same [9:8], selects the remembered slot directly with no second byte.
REQ-023 The 10-bit history (valid flag + slot index) is set on a 10-bit write match and cleared on reset, on enable falling without a restart, or on any non-matching address phase.
REQ-024 done asserts in the FPGA_clk cycle after the deciding sample edge; the state then holds in RESOLVED, ignoring SCL, until IDLE.
REQ-025 A sample edge coincident with enable falling or restart is discarded.
REQ-026 Reserved 7-bit addresses (0000xxx except GC, 1111xxx) never match a 7-bit slot.

Reset
REQ-027 While rst=0: state=IDLE, shift register=0, bit counter=0, history cleared, and done, selected, general_call, rw, match_idx all 0.
REQ-028 Reset asserted mid-byte aborts the decode immediately; no done pulse follows deassertion.

Structure
REQ-029 i2c_pkg holds the state enum, HDR_10BIT=5'b11110, GC_ADDR=7'h00 and START_BYTE=8'h01.
REQ-030 The bit count uses the existing counter sub-module, instantiated with WIDTH=4 and cleared on each state entry.
REQ-031 Slot comparison is a combinational for-loop priority encoder inside i2c_addr_match; there are no further sub-modules.

Verification
REQ-032 Slot0=7'h42 (7-bit); send 0x85 -> done pulse, selected=1, match_idx=0, rw=1.
REQ-033 Slot1=10'h2A5 (10-bit); send 0xF4, ACK clock, 0xA5 -> done after byte2, selected=1, match_idx=1, rw=0.
REQ-034 After REQ-033, restart then 0xF5 -> done after 8 edges, selected=1, match_idx=1, rw=1; without the prior write -> selected=0.
REQ-035 Send 0x00 with GC_EN=1 -> selected=1, general_call=1; send 0x01 -> done, selected=0.
REQ-036 enable drops after 4 bits -> outputs clear, no done; rst pulled low mid-byte -> all outputs 0 next cycle.
REQ-037 Slots 0 and 1 both 7'h10; send 0x20 -> match_idx=0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave address decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_pkg;

   // Address-phase decode states
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      BYTE1    = 3'd1,
      ACK1     = 3'd2,
      BYTE2    = 3'd3,
      RESOLVED = 3'd4
   } state_e;

   // Upper five bits of a 10-bit addressing header byte
   localparam logic [4:0] HDR_10BIT  = 5'b11110;
   // General-call address (with rw=0 it forms byte 0x00)
   localparam logic [6:0] GC_ADDR    = 7'h00;
   // START byte, never acknowledged
   localparam logic [7:0] START_BYTE = 8'h01;

   // 0000xxx and 1111xxx are reserved and never match a 7-bit slot
   function automatic logic is_reserved7(input logic [6:0] addr);
      return (addr[6:3] == 4'b0000) || (addr[6:3] == 4'b1111);
   endfunction

endpackage

// File: rtl/i2c_addr_match_counter.sv
// Small up-counter with synchronous clear (clear wins over increment).
// Latency: count updates on the clock edge after clr_i/inc_i.
// Backpressure: none.
module i2c_addr_match_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: clear has priority over increment
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/i2c_addr_match.sv
// I2C slave address-phase decoder: 7-bit, 10-bit and general-call matching against a slot table.
// Latency: done pulses one FPGA_clk cycle after the deciding SCL sample edge.
// Backpressure: none; paced by SCL sample edges, aborted by enable low or restart.
module i2c_addr_match
   import i2c_pkg::*;
#(
   parameter int NUM_ADDR   = 2,
   parameter bit TEN_BIT_EN = 1'b1,
   parameter bit GC_EN      = 1'b1,
   localparam int IDX_W     = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1
) (
   input  logic                   FPGA_clk,
   input  logic                   rst,
   input  logic                   SCL,
   input  logic                   SCL_prev,
   input  logic                   SDA,
   input  logic                   enable,
   input  logic                   restart,
   input  logic [NUM_ADDR*10-1:0] addr_table,
   input  logic [NUM_ADDR-1:0]    addr_is_10bit,
   output logic                   done,
   output logic                   selected,
   output logic                   general_call,
   output logic                   rw,
   output logic [IDX_W-1:0]       match_idx
);

   state_e           state_q, state_d;
   logic [7:0]       shift_q, shift_d;
   logic [1:0]       hdr_q, hdr_d;
   logic             done_q, done_d;
   logic             sel_q, sel_d;
   logic             gc_q, gc_d;
   logic             rw_q, rw_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             hist_vld_q, hist_vld_d;
   logic [IDX_W-1:0] hist_idx_q, hist_idx_d;
   logic [1:0]       hist_hi_q, hist_hi_d;

   logic             sample;
   logic             abort;
   logic [7:0]       byte_in;
   logic [3:0]       bit_cnt;
   logic             cnt_clr;
   logic             cnt_inc;

   logic             m7_hit;
   logic [IDX_W-1:0] m7_idx;
   logic             m10_hit;
   logic [IDX_W-1:0] m10_idx;
   logic             hdr_any;

   assign sample  = SCL & ~SCL_prev;
   assign abort   = ~enable | restart;
   // Byte as it will look once the current SDA bit is shifted in
   assign byte_in = {shift_q[6:0], SDA};
   // Every state entry (including aborts) restarts the bit count
   assign cnt_clr = (state_d != state_q) | abort;

   i2c_addr_match_counter #(
      .WIDTH (4)
   ) u_bit_cnt (
      .clk_i   (FPGA_clk),
      .rst_ni  (rst),
      .clr_i   (cnt_clr),
      .inc_i   (cnt_inc),
      .count_o (bit_cnt)
   );

   // Slot priority encoders; descending scan so the lowest index wins
   always_comb begin
      m7_hit  = 1'b0;
      m7_idx  = '0;
      m10_hit = 1'b0;
      m10_idx = '0;
      hdr_any = 1'b0;
      for (int i = NUM_ADDR - 1; i >= 0; i--) begin
         if (!addr_is_10bit[i] && (addr_table[10*i +: 7] == byte_in[7:1])) begin
            m7_hit = 1'b1;
            m7_idx = IDX_W'(i);
         end
         if (addr_is_10bit[i] && (addr_table[10*i +: 10] == {hdr_q, byte_in})) begin
            m10_hit = 1'b1;
            m10_idx = IDX_W'(i);
         end
         if (addr_is_10bit[i] && (addr_table[10*i+8 +: 2] == byte_in[2:1])) begin
            hdr_any = 1'b1;
         end
      end
   end

   // Next-state, decode results and 10-bit history
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      hdr_d      = hdr_q;
      done_d     = 1'b0;
      sel_d      = sel_q;
      gc_d       = gc_q;
      rw_d       = rw_q;
      idx_d      = idx_q;
      hist_vld_d = hist_vld_q;
      hist_idx_d = hist_idx_q;
      hist_hi_d  = hist_hi_q;
      cnt_inc    = 1'b0;

      if (abort) begin
         // Any sample edge in this cycle is dropped along with the decode
         state_d = IDLE;
         shift_d = '0;
         sel_d   = 1'b0;
         gc_d    = 1'b0;
         rw_d    = 1'b0;
         idx_d   = '0;
         // A repeated START keeps the history so a 10-bit read can follow
         if (!enable && !restart) begin
            hist_vld_d = 1'b0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               state_d = BYTE1;
               shift_d = '0;
            end

            BYTE1: begin
               if (sample) begin
                  shift_d = byte_in;
                  cnt_inc = 1'b1;
                  if (bit_cnt == 4'd7) begin
                     rw_d    = byte_in[0];
                     done_d  = 1'b1;
                     state_d = RESOLVED;
                     if (byte_in[7:3] == HDR_10BIT) begin
                        if (!TEN_BIT_EN) begin
                           hist_vld_d = 1'b0;
                        end else if (!byte_in[0]) begin
                           if (hdr_any) begin
                              // Second address byte still to come
                              state_d = ACK1;
                              done_d  = 1'b0;
                              hdr_d   = byte_in[2:1];
                           end else begin
                              hist_vld_d = 1'b0;
                           end
                        end else if (hist_vld_q && (hist_hi_q == byte_in[2:1])) begin
                           sel_d = 1'b1;
                           idx_d = hist_idx_q;
                        end else begin
                           hist_vld_d = 1'b0;
                        end
                     end else if (GC_EN && (byte_in == {GC_ADDR, 1'b0})) begin
                        sel_d = 1'b1;
                        gc_d  = 1'b1;
                        idx_d = '0;
                     end else if ((byte_in != START_BYTE) && !is_reserved7(byte_in[7:1]) && m7_hit) begin
                        sel_d = 1'b1;
                        idx_d = m7_idx;
                     end else begin
                        hist_vld_d = 1'b0;
                     end
                  end
               end
            end

            ACK1: begin
               // The ACK clock carries no address data
               if (sample) begin
                  state_d = BYTE2;
                  shift_d = '0;
               end
            end

            BYTE2: begin
               if (sample) begin
                  shift_d = byte_in;
                  cnt_inc = 1'b1;
                  if (bit_cnt == 4'd7) begin
                     done_d  = 1'b1;
                     rw_d    = 1'b0;
                     state_d = RESOLVED;
                     if (m10_hit) begin
                        sel_d      = 1'b1;
                        idx_d      = m10_idx;
                        hist_vld_d = 1'b1;
                        hist_idx_d = m10_idx;
                        hist_hi_d  = hdr_q;
                     end else begin
                        hist_vld_d = 1'b0;
                     end
                  end
               end
            end

            RESOLVED: begin
               // Result held, SCL ignored until enable drops or restart
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and result registers
   always_ff @(posedge FPGA_clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         hdr_q      <= '0;
         done_q     <= 1'b0;
         sel_q      <= 1'b0;
         gc_q       <= 1'b0;
         rw_q       <= 1'b0;
         idx_q      <= '0;
         hist_vld_q <= 1'b0;
         hist_idx_q <= '0;
         hist_hi_q  <= '0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         hdr_q      <= hdr_d;
         done_q     <= done_d;
         sel_q      <= sel_d;
         gc_q       <= gc_d;
         rw_q       <= rw_d;
         idx_q      <= idx_d;
         hist_vld_q <= hist_vld_d;
         hist_idx_q <= hist_idx_d;
         hist_hi_q  <= hist_hi_d;
      end
   end

   assign done         = done_q;
   assign selected     = sel_q;
   assign general_call = gc_q;
   assign rw           = rw_q;
   assign match_idx    = idx_q;

endmodule

// File: tb/tb_i2c_addr_match.sv
// Directed bench for the I2C address decoder: vector table plus multi-cycle sequences.
// Latency: checks done one cycle after the deciding sample edge.
// Backpressure: n/a.
module tb_i2c_addr_match;

   logic        FPGA_clk;
   logic        rst;
   logic        SCL;
   logic        SCL_prev;
   logic        SDA;
   logic        enable;
   logic        restart;
   logic [19:0] addr_table;
   logic [1:0]  addr_is_10bit;
   logic        done;
   logic        selected;
   logic        general_call;
   logic        rw;
   logic [0:0]  match_idx;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;
   int snap;

   i2c_addr_match #(
      .NUM_ADDR   (2),
      .TEN_BIT_EN (1'b1),
      .GC_EN      (1'b1)
   ) dut (
      .FPGA_clk      (FPGA_clk),
      .rst           (rst),
      .SCL           (SCL),
      .SCL_prev      (SCL_prev),
      .SDA           (SDA),
      .enable        (enable),
      .restart       (restart),
      .addr_table    (addr_table),
      .addr_is_10bit (addr_is_10bit),
      .done          (done),
      .selected      (selected),
      .general_call  (general_call),
      .rw            (rw),
      .match_idx     (match_idx)
   );

   initial FPGA_clk = 1'b0;
   always #5 FPGA_clk = ~FPGA_clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       nm;
      logic [19:0] tbl;
      logic [1:0]  is10;
      logic [7:0]  b;
      logic        sel;
      logic        gc;
      logic        rwx;
      logic [0:0]  idx;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // One FPGA_clk cycle: drive at negedge, observe 1ns after posedge
   task automatic tick(input logic scl, input logic sda, input logic rs);
      @(negedge FPGA_clk);
      SCL_prev = SCL;
      SCL      = scl;
      SDA      = sda;
      restart  = rs;
      @(posedge FPGA_clk);
      #1;
      if (done === 1'b1) done_cnt++;
   endtask

   task automatic send_bit(input logic b);
      tick(1'b0, b, 1'b0);
      tick(1'b1, b, 1'b0);
      tick(1'b1, b, 1'b0);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic exp_done, input string nm);
      for (int i = 7; i >= 0; i--) begin
         tick(1'b0, b[i], 1'b0);
         tick(1'b1, b[i], 1'b0);
         if (i == 0) chk({nm, "_done"}, 32'(done), 32'(exp_done));
         tick(1'b1, b[i], 1'b0);
      end
   endtask

   task automatic start_txn();
      enable = 1'b1;
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
   endtask

   task automatic end_txn();
      enable = 1'b0;
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
   endtask

   task automatic pulse_restart();
      tick(1'b0, 1'b1, 1'b1);
      tick(1'b0, 1'b1, 1'b0);
   endtask

   task automatic chk_out(input string nm, input logic s, input logic g, input logic r, input logic [0:0] ix);
      chk({nm, "_sel"}, 32'(selected), 32'(s));
      chk({nm, "_gc"},  32'(general_call), 32'(g));
      chk({nm, "_rw"},  32'(rw), 32'(r));
      chk({nm, "_idx"}, 32'(match_idx), 32'(ix));
   endtask

   initial begin
      //                name          {slot1,slot0}        is10   byte   sel  gc   rw   idx
      vecs[0]  = '{"m7_read",    {10'h2A5, 10'h042}, 2'b10, 8'h85, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{"gencall",    {10'h2A5, 10'h042}, 2'b10, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{"startbyte",  {10'h2A5, 10'h042}, 2'b10, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{"dup_low",    {10'h010, 10'h010}, 2'b00, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{"slot1",      {10'h033, 10'h042}, 2'b00, 8'h66, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[5]  = '{"rsv_high",   {10'h033, 10'h07C}, 2'b00, 8'hF8, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{"rsv_low",    {10'h033, 10'h005}, 2'b00, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{"rd10_nohist",{10'h2A5, 10'h042}, 2'b10, 8'hF5, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{"hdr_miss",   {10'h2A5, 10'h042}, 2'b10, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{"m7_miss",    {10'h2A5, 10'h042}, 2'b10, 8'h90, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{"slot10_lo7", {10'h2A5, 10'h042}, 2'b10, 8'h4A, 1'b0, 1'b0, 1'b0, 1'b0};

      rst = 1'b0; enable = 1'b0; restart = 1'b0;
      SCL = 1'b1; SCL_prev = 1'b1; SDA = 1'b1;
      addr_table = {10'h2A5, 10'h042}; addr_is_10bit = 2'b10;

      // Reset state
      repeat (3) @(posedge FPGA_clk);
      #1;
      chk("rst_done", 32'(done), 32'd0);
      chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge FPGA_clk);
      rst = 1'b1;
      tick(1'b0, 1'b1, 1'b0);

      // Single-byte vectors
      for (int v = 0; v < NV; v++) begin
         addr_table    = vecs[v].tbl;
         addr_is_10bit = vecs[v].is10;
         snap = done_cnt;
         start_txn();
         send_byte(vecs[v].b, 1'b1, vecs[v].nm);
         chk({vecs[v].nm, "_pulse"}, 32'(done), 32'd0);
         chk({vecs[v].nm, "_ndone"}, 32'(done_cnt - snap), 32'd1);
         chk_out(vecs[v].nm, vecs[v].sel, vecs[v].gc, vecs[v].rwx, vecs[v].idx);
         end_txn();
      end
      chk_out("after_end", 1'b0, 1'b0, 1'b0, 1'b0);

      // 10-bit write: header, ACK clock, second byte
      addr_table = {10'h2A5, 10'h042}; addr_is_10bit = 2'b10;
      snap = done_cnt;
      start_txn();
      send_byte(8'hF4, 1'b0, "w10_hdr");
      send_bit(1'b0);
      chk("w10_ack_nodone", 32'(done_cnt - snap), 32'd0);
      send_byte(8'hA5, 1'b1, "w10_b2");
      chk_out("w10", 1'b1, 1'b0, 1'b0, 1'b1);

      // Repeated START then 10-bit read header uses remembered slot
      tick(1'b0, 1'b1, 1'b1);
      chk("rs_clear_sel", 32'(selected), 32'd0);
      tick(1'b0, 1'b1, 1'b0);
      send_byte(8'hF5, 1'b1, "r10");
      chk_out("r10", 1'b1, 1'b0, 1'b1, 1'b1);
      end_txn();

      // Read header after STOP: history gone
      start_txn();
      send_byte(8'hF5, 1'b1, "r10_stop");
      chk_out("r10_stop", 1'b0, 1'b0, 1'b1, 1'b0);
      end_txn();

      // enable drops after 4 bits; sample edge coincident with the drop is discarded
      snap = done_cnt;
      start_txn();
      send_bits(8'h85, 4);
      tick(1'b0, 1'b0, 1'b0);
      enable = 1'b0;
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      chk("abort_nodone", 32'(done_cnt - snap), 32'd0);
      chk_out("abort", 1'b0, 1'b0, 1'b0, 1'b0);
      start_txn();
      send_byte(8'h85, 1'b1, "after_abort");
      chk_out("after_abort", 1'b1, 1'b0, 1'b1, 1'b0);
      end_txn();

      // Reset mid-byte with history armed
      start_txn();
      send_byte(8'hF4, 1'b0, "h2");
      send_bit(1'b0);
      send_byte(8'hA5, 1'b1, "h2_b2");
      chk_out("h2", 1'b1, 1'b0, 1'b0, 1'b1);
      pulse_restart();
      send_bits(8'hF5, 3);
      tick(1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      #1;
      chk("midrst_done", 32'(done), 32'd0);
      chk_out("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      @(negedge FPGA_clk);
      rst = 1'b1;
      snap = done_cnt;
      send_bits(8'h5A, 5);
      tick(1'b0, 1'b1, 1'b0);
      chk("postrst_nodone", 32'(done_cnt - snap), 32'd0);
      pulse_restart();
      send_byte(8'hF5, 1'b1, "r10_postrst");
      chk_out("r10_postrst", 1'b0, 1'b0, 1'b1, 1'b0);

      // Unlocked second restart of a 10-bit read with a different [9:8] misses
      end_txn();
      start_txn();
      send_byte(8'hF4, 1'b0, "h3");
      send_bit(1'b0);
      send_byte(8'hA5, 1'b1, "h3_b2");
      pulse_restart();
      send_byte(8'hF3, 1'b1, "r10_wronghi");
      chk_out("r10_wronghi", 1'b0, 1'b0, 1'b1, 1'b0);
      end_txn();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
